// File: rtl/spi_master_ctrl.sv
`default_nettype none
// ============================================================================
// spi_master_ctrl : SPI master, all CPOL/CPHA modes, MSB/LSB-first, NUM_CS selects
// Revision 1.0
// ============================================================================
module spi_master_ctrl #(
   parameter int DATA_W  = 8,
   parameter int CLK_DIV = 4,
   parameter int NUM_CS  = 1,
   parameter int CS_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
   input  logic              i_clk,
   input  logic              rst_n,
   input  logic              i_start,
   input  logic [DATA_W-1:0] i_tx_data,
   input  logic [CS_W-1:0]   i_cs_sel,
   input  logic              i_cpol,
   input  logic              i_cpha,
   input  logic              i_msb_first,
   output logic              o_busy,
   output logic              o_done,
   output logic [DATA_W-1:0] o_rx_data,
   output logic              o_spi_clk,
   output logic              o_spi_mosi,
   input  logic              i_spi_miso,
   output logic [NUM_CS-1:0] o_spi_cs_n
);
   localparam int DIV_W  = $clog2(CLK_DIV + 1);
   localparam int EDGE_W = $clog2(2 * DATA_W + 1);
   localparam logic [DIV_W-1:0]  c_div_last  = DIV_W'(CLK_DIV - 1);
   localparam logic [EDGE_W-1:0] c_last_edge = EDGE_W'(2 * DATA_W);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_XFER  = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [DIV_W-1:0]    div_q, div_d;
   logic [EDGE_W-1:0]   edge_q, edge_d, edge_nxt;
   logic                cpol_q, cpol_d, cpha_q, cpha_d, msb_q, msb_d;
   logic [DATA_W-1:0]   tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
   logic                busy_q, busy_d, done_q, done_d;
   logic                sclk_q, sclk_d, mosi_q, mosi_d;
   logic [NUM_CS-1:0]   cs_n_q, cs_n_d;
   logic                div_end, leading, last_edge, do_sample, do_advance;

   function automatic logic head_bit(input logic [DATA_W-1:0] w, input logic msb);
      return msb ? w[DATA_W-1] : w[0];
   endfunction

   function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w, input logic msb);
      return msb ? (w << 1) : (w >> 1);
   endfunction

   // Out-of-range indices match no bit, so no select is asserted.
   function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
      logic [NUM_CS-1:0] v;
      v = '1;
      for (int i = 0; i < NUM_CS; i++) begin
         if (sel == CS_W'(i)) v[i] = 1'b0;
      end
      return v;
   endfunction

   assign div_end    = (div_q == c_div_last);
   assign edge_nxt   = edge_q + EDGE_W'(1);
   assign leading    = edge_nxt[0];
   assign last_edge  = (edge_nxt == c_last_edge);
   assign do_sample  = leading ^ cpha_q;
   assign do_advance = cpha_q ? leading : (!leading && !last_edge);

   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      edge_d    = edge_q;
      cpol_d    = cpol_q;
      cpha_d    = cpha_q;
      msb_d     = msb_q;
      tx_sh_d   = tx_sh_q;
      rx_sh_d   = rx_sh_q;
      rx_data_d = rx_data_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      sclk_d    = sclk_q;
      mosi_d    = mosi_q;
      cs_n_d    = cs_n_q;
      case (state_q)
         ST_IDLE: begin
            sclk_d = cpol_q;
            if (i_start) begin
               state_d = ST_SETUP;
               div_d   = '0;
               edge_d  = '0;
               cpol_d  = i_cpol;
               cpha_d  = i_cpha;
               msb_d   = i_msb_first;
               rx_sh_d = '0;
               busy_d  = 1'b1;
               sclk_d  = i_cpol;
               cs_n_d  = cs_decode(i_cs_sel);
               // CPHA=0 must present the first bit before the first SCLK edge.
               if (!i_cpha) begin
                  mosi_d  = head_bit(i_tx_data, i_msb_first);
                  tx_sh_d = shift_out(i_tx_data, i_msb_first);
               end else begin
                  tx_sh_d = i_tx_data;
               end
            end
         end
         ST_SETUP, ST_XFER: begin
            div_d = div_end ? '0 : div_q + DIV_W'(1);
            if (div_end) begin
               edge_d  = edge_nxt;
               sclk_d  = ~sclk_q;
               state_d = last_edge ? ST_HOLD : ST_XFER;
               if (do_sample) begin
                  rx_sh_d = msb_q ? {rx_sh_q[DATA_W-2:0], i_spi_miso}
                                  : {i_spi_miso, rx_sh_q[DATA_W-1:1]};
               end
               if (do_advance) begin
                  mosi_d  = head_bit(tx_sh_q, msb_q);
                  tx_sh_d = shift_out(tx_sh_q, msb_q);
               end
            end
         end
         ST_HOLD: begin
            div_d = div_end ? '0 : div_q + DIV_W'(1);
            if (div_end) begin
               state_d   = ST_IDLE;
               edge_d    = '0;
               busy_d    = 1'b0;
               done_d    = 1'b1;
               cs_n_d    = '1;
               rx_data_d = rx_sh_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         div_q     <= '0;
         edge_q    <= '0;
         cpol_q    <= 1'b0;
         cpha_q    <= 1'b0;
         msb_q     <= 1'b0;
         tx_sh_q   <= '0;
         rx_sh_q   <= '0;
         rx_data_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         sclk_q    <= 1'b0;
         mosi_q    <= 1'b0;
         cs_n_q    <= '1;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         edge_q    <= edge_d;
         cpol_q    <= cpol_d;
         cpha_q    <= cpha_d;
         msb_q     <= msb_d;
         tx_sh_q   <= tx_sh_d;
         rx_sh_q   <= rx_sh_d;
         rx_data_q <= rx_data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         sclk_q    <= sclk_d;
         mosi_q    <= mosi_d;
         cs_n_q    <= cs_n_d;
      end
   end

   assign o_busy     = busy_q;
   assign o_done     = done_q;
   assign o_rx_data  = rx_data_q;
   assign o_spi_clk  = sclk_q;
   assign o_spi_mosi = mosi_q;
   assign o_spi_cs_n = cs_n_q;
endmodule
`default_nettype wire

// File: tb/tb_spi_master_ctrl.sv
`default_nettype none
// Bench for spi_master_ctrl: expected words and done cycles are queued at accept
// and compared when o_done fires; a behavioural slave captures MOSI and drives MISO.
module tb_spi_master_ctrl;
   localparam int DATA_W  = 8;
   localparam int CLK_DIV = 2;
   localparam int NUM_CS  = 4;
   localparam int CS_W    = 2;
   localparam int LAT     = 1 + (2 * DATA_W + 1) * CLK_DIV;

   logic              i_clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              i_start = 1'b0;
   logic [DATA_W-1:0] i_tx_data = '0;
   logic [CS_W-1:0]   i_cs_sel = '0;
   logic              i_cpol = 1'b0, i_cpha = 1'b0, i_msb_first = 1'b1;
   logic              o_busy, o_done, o_spi_clk, o_spi_mosi;
   logic [DATA_W-1:0] o_rx_data;
   logic [NUM_CS-1:0] o_spi_cs_n;
   logic              tb_miso;

   spi_master_ctrl #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .NUM_CS(NUM_CS), .CS_W(CS_W)) dut (
      .i_clk(i_clk), .rst_n(rst_n), .i_start(i_start), .i_tx_data(i_tx_data),
      .i_cs_sel(i_cs_sel), .i_cpol(i_cpol), .i_cpha(i_cpha), .i_msb_first(i_msb_first),
      .o_busy(o_busy), .o_done(o_done), .o_rx_data(o_rx_data), .o_spi_clk(o_spi_clk),
      .o_spi_mosi(o_spi_mosi), .i_spi_miso(tb_miso), .o_spi_cs_n(o_spi_cs_n)
   );

   always #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc++;

   typedef struct { logic [7:0] rx; logic [7:0] mosi; int dcyc; } exp_t;
   exp_t exp_q[$];
   int   n_checks = 0, n_fail = 0, rd = 0;

   // Slave configuration, set by the stimulus before each accept
   logic       s_cpol = 1'b0, s_cpha = 1'b0, s_msb = 1'b1, s_loop = 1'b1;
   logic [7:0] s_word = '0;

   // Slave state and done-time observations, owned by the negedge process
   logic       s_bit = 1'b0, sclk_prev = 1'b0, sel_prev = 1'b0, sel, lead;
   int         s_tx_idx = 0, s_rx_idx = 0, s_rise = 0, s_hi = 0, n_done = 0;
   logic [7:0] s_rx_word = '0;
   logic [7:0] obs_rx[16], obs_word[16];
   int         obs_rise[16], obs_hi[16], obs_cyc[16];

   always @(negedge i_clk) begin
      sel = (o_spi_cs_n != '1);
      if (sel && !sel_prev) begin
         s_tx_idx = 0; s_rx_idx = 0; s_rx_word = '0; s_rise = 0; s_hi = 0;
         if (!s_cpha) begin
            s_bit = s_word[s_msb ? 7 : 0];
            s_tx_idx = 1;
         end
      end else if (sel && (o_spi_clk != sclk_prev)) begin
         lead = (o_spi_clk != s_cpol);
         if (o_spi_clk) s_rise++;
         if (lead ^ s_cpha) begin
            if (s_rx_idx < 8) s_rx_word[s_msb ? 7 - s_rx_idx : s_rx_idx] = o_spi_mosi;
            if (o_spi_mosi) s_hi++;
            s_rx_idx++;
         end else if (s_tx_idx < 8) begin
            s_bit = s_word[s_msb ? 7 - s_tx_idx : s_tx_idx];
            s_tx_idx++;
         end
      end
      if (o_done && n_done < 16) begin
         obs_rx[n_done] = o_rx_data; obs_word[n_done] = s_rx_word;
         obs_rise[n_done] = s_rise; obs_hi[n_done] = s_hi; obs_cyc[n_done] = cyc;
         n_done++;
      end
      sclk_prev = o_spi_clk;
      sel_prev  = sel;
   end

   assign tb_miso = s_loop ? o_spi_mosi : s_bit;

   task automatic start_xfer(input logic [7:0] tx, input logic [1:0] cs, input logic cpol,
                             input logic cpha, input logic msb, input logic [7:0] mword,
                             input logic loop);
      exp_t e;
      s_cpol = cpol; s_cpha = cpha; s_msb = msb; s_word = mword; s_loop = loop;
      i_tx_data = tx; i_cs_sel = cs; i_cpol = cpol; i_cpha = cpha; i_msb_first = msb;
      i_start = 1'b1;
      @(posedge i_clk); #1;
      i_start = 1'b0;
      e.rx = loop ? tx : mword; e.mosi = tx; e.dcyc = cyc - 1 + LAT;
      exp_q.push_back(e);
   endtask

   task automatic wait_done(input int target, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 4 * LAT && !ok; i++) begin
         @(negedge i_clk); #1;
         ok = (n_done >= target);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; #12;
      n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", o_busy); end
      n_checks++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", o_done); end
      n_checks++; if (o_rx_data !== 8'h00) begin n_fail++; $display("FAIL rst_rx: got %h want 00", o_rx_data); end
      n_checks++; if (o_spi_clk !== 1'b0) begin n_fail++; $display("FAIL rst_sclk: got %b want 0", o_spi_clk); end
      n_checks++; if (o_spi_mosi !== 1'b0) begin n_fail++; $display("FAIL rst_mosi: got %b want 0", o_spi_mosi); end
      n_checks++; if (o_spi_cs_n !== 4'hF) begin n_fail++; $display("FAIL rst_cs: got %b want 1111", o_spi_cs_n); end
      @(negedge i_clk); #1 rst_n = 1'b1;
      repeat (3) @(negedge i_clk);
      n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle_busy: got %b want 0", o_busy); end
   endtask

   task automatic test_mode0;
      exp_t e; bit ok;
      start_xfer(8'hA5, 2'd0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1);
      n_checks++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL m0_busy: got %b want 1", o_busy); end
      n_checks++; if (o_spi_cs_n !== 4'b1110) begin n_fail++; $display("FAIL m0_cs: got %b want 1110", o_spi_cs_n); end
      n_checks++; if (o_spi_mosi !== 1'b1) begin n_fail++; $display("FAIL m0_first_mosi: got %b want 1", o_spi_mosi); end
      wait_done(rd + 1, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL m0_timeout: got no done want done"); end
      n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL m0_done_busy: got %b want 0", o_busy); end
      e = exp_q.pop_front();
      n_checks++; if (obs_rx[rd] !== e.rx) begin n_fail++; $display("FAIL m0_rx: got %h want %h", obs_rx[rd], e.rx); end
      n_checks++; if (obs_word[rd] !== e.mosi) begin n_fail++; $display("FAIL m0_mosi_bits: got %h want %h", obs_word[rd], e.mosi); end
      n_checks++; if (obs_rise[rd] != 8) begin n_fail++; $display("FAIL m0_rising: got %0d want 8", obs_rise[rd]); end
      n_checks++; if (obs_cyc[rd] != e.dcyc) begin n_fail++; $display("FAIL m0_latency: got cycle %0d want %0d", obs_cyc[rd], e.dcyc); end
      rd++;
      repeat (3) @(negedge i_clk);
   endtask

   task automatic test_mode3;
      exp_t e; bit ok;
      start_xfer(8'h3C, 2'd0, 1'b1, 1'b1, 1'b1, 8'hC3, 1'b0);
      n_checks++; if (o_spi_clk !== 1'b1) begin n_fail++; $display("FAIL m3_idle_pre: got %b want 1", o_spi_clk); end
      wait_done(rd + 1, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL m3_timeout: got no done want done"); end
      e = exp_q.pop_front();
      n_checks++; if (obs_rx[rd] !== e.rx) begin n_fail++; $display("FAIL m3_rx: got %h want %h", obs_rx[rd], e.rx); end
      n_checks++; if (obs_word[rd] !== e.mosi) begin n_fail++; $display("FAIL m3_mosi_bits: got %h want %h", obs_word[rd], e.mosi); end
      n_checks++; if (obs_rise[rd] != 8) begin n_fail++; $display("FAIL m3_rising: got %0d want 8", obs_rise[rd]); end
      rd++;
      repeat (3) @(negedge i_clk);
      n_checks++; if (o_spi_clk !== 1'b1) begin n_fail++; $display("FAIL m3_idle_post: got %b want 1", o_spi_clk); end
   endtask

   task automatic test_lsb_mode1;
      exp_t e; bit ok;
      start_xfer(8'h01, 2'd0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
      wait_done(rd + 1, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL lsb_timeout: got no done want done"); end
      e = exp_q.pop_front();
      n_checks++; if (obs_rx[rd] !== e.rx) begin n_fail++; $display("FAIL lsb_rx: got %h want %h", obs_rx[rd], e.rx); end
      n_checks++; if (obs_word[rd] !== e.mosi) begin n_fail++; $display("FAIL lsb_mosi_bits: got %h want %h", obs_word[rd], e.mosi); end
      n_checks++; if (obs_hi[rd] != 1) begin n_fail++; $display("FAIL lsb_mosi_high: got %0d want 1", obs_hi[rd]); end
      rd++;
      repeat (3) @(negedge i_clk);
   endtask

   task automatic test_cs_ignore;
      exp_t e; bit ok;
      start_xfer(8'h5A, 2'd2, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1);
      n_checks++; if (o_spi_cs_n !== 4'b1011) begin n_fail++; $display("FAIL cs_sel2: got %b want 1011", o_spi_cs_n); end
      repeat (9) @(posedge i_clk);
      #1;
      i_start = 1'b1; i_tx_data = 8'hFF; i_cs_sel = 2'd0; i_cpha = 1'b1; i_msb_first = 1'b0;
      @(posedge i_clk); #1;
      i_start = 1'b0;
      n_checks++; if (o_spi_cs_n !== 4'b1011) begin n_fail++; $display("FAIL cs_hold: got %b want 1011", o_spi_cs_n); end
      wait_done(rd + 1, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL cs_timeout: got no done want done"); end
      e = exp_q.pop_front();
      n_checks++; if (obs_rx[rd] !== e.rx) begin n_fail++; $display("FAIL cs_rx: got %h want %h", obs_rx[rd], e.rx); end
      n_checks++; if (obs_word[rd] !== e.mosi) begin n_fail++; $display("FAIL cs_mosi_bits: got %h want %h", obs_word[rd], e.mosi); end
      rd++;
      repeat (2 * LAT) @(negedge i_clk);
      n_checks++; if (n_done != rd) begin n_fail++; $display("FAIL cs_one_done: got %0d dones want %0d", n_done, rd); end
   endtask

   task automatic test_back_to_back;
      exp_t e; bit ok; int t;
      s_cpol = 1'b0; s_cpha = 1'b0; s_msb = 1'b1; s_loop = 1'b1; s_word = 8'h00;
      i_tx_data = 8'h96; i_cs_sel = 2'd0; i_cpol = 1'b0; i_cpha = 1'b0; i_msb_first = 1'b1;
      i_start = 1'b1;
      @(posedge i_clk); #1;
      t = cyc - 1;
      e.rx = 8'h96; e.mosi = 8'h96; e.dcyc = t + LAT;     exp_q.push_back(e);
      e.rx = 8'h69; e.mosi = 8'h69; e.dcyc = t + 2 * LAT; exp_q.push_back(e);
      i_tx_data = 8'h69;
      wait_done(rd + 1, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_timeout1: got no done want done"); end
      n_checks++; if (o_spi_cs_n !== 4'hF) begin n_fail++; $display("FAIL b2b_cs_gap: got %b want 1111", o_spi_cs_n); end
      @(posedge i_clk); #1;
      i_start = 1'b0;
      n_checks++; if (o_spi_cs_n !== 4'b1110) begin n_fail++; $display("FAIL b2b_cs_reassert: got %b want 1110", o_spi_cs_n); end
      n_checks++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b want 1", o_busy); end
      e = exp_q.pop_front();
      n_checks++; if (obs_rx[rd] !== e.rx) begin n_fail++; $display("FAIL b2b_rx1: got %h want %h", obs_rx[rd], e.rx); end
      n_checks++; if (obs_cyc[rd] != e.dcyc) begin n_fail++; $display("FAIL b2b_cyc1: got %0d want %0d", obs_cyc[rd], e.dcyc); end
      rd++;
      wait_done(rd + 1, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_timeout2: got no done want done"); end
      e = exp_q.pop_front();
      n_checks++; if (obs_rx[rd] !== e.rx) begin n_fail++; $display("FAIL b2b_rx2: got %h want %h", obs_rx[rd], e.rx); end
      n_checks++; if (obs_word[rd] !== e.mosi) begin n_fail++; $display("FAIL b2b_mosi2: got %h want %h", obs_word[rd], e.mosi); end
      n_checks++; if (obs_cyc[rd] != e.dcyc) begin n_fail++; $display("FAIL b2b_cyc2: got %0d want %0d", obs_cyc[rd], e.dcyc); end
      rd++;
      repeat (3) @(negedge i_clk);
   endtask

   task automatic test_reset_mid;
      exp_t e; bit ok;
      start_xfer(8'hC3, 2'd0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1);
      repeat (11) @(posedge i_clk);
      #1 rst_n = 1'b0;
      #1;
      n_checks++; if (o_spi_cs_n !== 4'hF) begin n_fail++; $display("FAIL rm_cs: got %b want 1111", o_spi_cs_n); end
      n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy: got %b want 0", o_busy); end
      n_checks++; if (o_rx_data !== 8'h00) begin n_fail++; $display("FAIL rm_rx: got %h want 00", o_rx_data); end
      n_checks++; if (o_spi_clk !== 1'b0) begin n_fail++; $display("FAIL rm_sclk: got %b want 0", o_spi_clk); end
      exp_q.delete();
      repeat (3) @(negedge i_clk);
      rst_n = 1'b1;
      repeat (2 * LAT) @(negedge i_clk);
      n_checks++; if (n_done != rd) begin n_fail++; $display("FAIL rm_no_done: got %0d dones want %0d", n_done, rd); end
      start_xfer(8'h3A, 2'd0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1);
      wait_done(rd + 1, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL rm_timeout: got no done want done"); end
      e = exp_q.pop_front();
      n_checks++; if (obs_rx[rd] !== e.rx) begin n_fail++; $display("FAIL rm_rx_after: got %h want %h", obs_rx[rd], e.rx); end
      n_checks++; if (obs_cyc[rd] != e.dcyc) begin n_fail++; $display("FAIL rm_latency: got %0d want %0d", obs_cyc[rd], e.dcyc); end
      rd++;
   endtask

   initial begin
      test_reset();
      test_mode0();
      test_mode3();
      test_lsb_mode1();
      test_cs_ignore();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1);
   end
endmodule
`default_nettype wire

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
Parametrised SPI master that shifts one DATA_W-bit word out on MOSI while capturing one word from MISO, per start request. Supports all four CPOL/CPHA modes, MSB- or LSB-first ordering, a programmable SCLK divider, and NUM_CS chip selects. It sits between on-chip control logic and the external SPI pins, and is the generalised successor of the single-mode spi_master shell.

Parameters:
DATA_W, 8, word length in bits (range 2..32).
CLK_DIV, 4, i_clk cycles per SCLK half-period (D); must be >= 1.
NUM_CS, 1, number of active-low chip selects (range 1..8).
CS_W, $clog2(NUM_CS) (minimum 1), width of the chip-select index.

Ports:
i_clk  in  1  system clock.
rst_n  in  1  reset: asynchronous, active-low. Clock is i_clk.
i_start  in  1  transfer request; accepted only when o_busy=0.
i_tx_data  in  DATA_W  word to transmit; latched on accept.
i_cs_sel  in  CS_W  chip-select index; latched on accept. Values >= NUM_CS select none.
i_cpol  in  1  SCLK idle level; latched on accept.
i_cpha  in  1  0: sample on leading edge; 1: sample on trailing edge. Latched on accept.
i_msb_first  in  1  1: MSB first; 0: LSB first. Latched on accept.
o_busy  out  1  high from the cycle after accept until the done cycle (exclusive).
o_done  out  1  single-cycle pulse when a transfer completes.
o_rx_data  out  DATA_W  last received word; valid from o_done, held until the next o_done.
o_spi_clk  out  1  SCLK.
o_spi_mosi  out  1  serial data out.
i_spi_miso  in  1  serial data in.
o_spi_cs_n  out  NUM_CS  active-low chip selects.

Behaviour:
- Reset values: o_busy=0, o_done=0, o_rx_data=0, o_spi_clk=0, o_spi_mosi=0, o_spi_cs_n=all 1s. Latched CPOL resets to 0; state=IDLE; all counters=0.
- All outputs are registered. In IDLE, o_spi_clk holds the latched CPOL, so it keeps the previous transfer's idle level.
- FSM states: IDLE, SETUP, XFER, HOLD.
  - IDLE: i_start=1 at cycle T latches the configuration -> SETUP at T+1.
  - SETUP: lasts D cycles. o_spi_cs_n[sel]=0 and o_busy=1 from T+1.
  - XFER: 2*DATA_W half-periods. SCLK edge k (k=1..2*DATA_W) is registered at cycle T+1+k*D. Odd k are leading edges, even k are trailing edges.
  - HOLD: D cycles after edge 2*DATA_W. CS stays asserted and SCLK stays at idle level.
  - At cycle T+1+(2*DATA_W+1)*D: state returns to IDLE, o_spi_cs_n goes all 1s, o_busy=0, o_done=1, and o_rx_data is updated in the same cycle.
- Total latency: accept to o_done = 1+(2*DATA_W+1)*D cycles. With DATA_W=8 and D=2 this is 35 cycles.
- CPHA=0:
  - The first bit drives MOSI from T+1.
  - MISO is sampled on each leading edge.
  - MOSI advances on each trailing edge, except the final edge.
- CPHA=1:
  - MOSI advances on each leading edge; the first bit appears at edge 1.
  - MISO is sampled on each trailing edge.
- Sampling point: i_spi_miso is captured in the same i_clk cycle that the SCLK toggle is registered.
- Bit order: the shift direction follows the latched msb_first, for both TX and RX. o_rx_data always presents the word in natural bit order.
- Start handling:
  - i_start while o_busy=1 is ignored, with no queueing.
  - i_start in the o_done cycle is accepted, giving back-to-back transfers. CS deasserts for exactly that one cycle.
- Input stability: changes to i_tx_data or config inputs during busy have no effect.
- Invalid chip select: if i_cs_sel >= NUM_CS, the transfer runs normally with no CS asserted.
- Reset mid-transfer: all outputs return to reset values immediately (asynchronously). No o_done pulse is produced, and o_rx_data is cleared to 0.
- Counters:
  - Divider counter: width $clog2(CLK_DIV+1), wraps at D-1.
  - Edge counter: width $clog2(2*DATA_W+1).
  - No arithmetic overflow is permitted at the maximum parameters.

Test Plan:
- Mode 0 (cpol=0, cpha=0), msb_first=1, DATA_W=8, D=2, tx=0xA5, MISO looped to MOSI -> o_done at T+35, o_rx_data=0xA5, 8 rising SCLK edges, MOSI bit sequence 1,0,1,0,0,1,0,1.
- Mode 3 (cpol=1, cpha=1), tx=0x3C, MISO driven by a model returning 0xC3 -> SCLK idles high before and after, o_rx_data=0xC3, samples taken on rising (trailing) edges.
- LSB-first, mode 1, tx=0x01, loopback -> MOSI high only for the first bit, o_rx_data=0x01.
- NUM_CS=4, cs_sel=2; i_start pulsed again at T+10 -> only o_spi_cs_n[2] goes low, the second start is ignored, exactly one o_done.
- Back-to-back: i_start held high through o_done -> second transfer starts at the o_done cycle, CS high for exactly 1 cycle, two o_done pulses 35 cycles apart.
- rst_n asserted at T+12 -> o_spi_cs_n=all 1s, o_busy=0, o_rx_data=0 immediately. No o_done pulse, and the next start after reset completes normally.
